board_score_keeper: RTL and testbench

- Registered storage stage directly downstream of the tic-tac-toe control FSM.
- Consumes the FSM's one-cycle placement masks, position reset, score-increment and score-reset levels.
- Holds the 9-cell X/O occupancy (fed back to the FSM as x/o), a move counter and per-player and draw BCD scoreboards for the display stage.

---
 rtl/tictactoe_pkg.sv | 28 ++
 rtl/bcd2_counter.sv | 33 +++
 rtl/board_score_keeper.sv | 98 +++++++++
 tb/tb_board_score_keeper.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// Shared types and helpers for the tic-tac-toe board/score storage stage.
package tictactoe_pkg;

  localparam int NCELLS = 9;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] BCD_MAX = 8'h99;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } cell_sel_t;

  // Lowest set bit wins; scanning downward leaves the smallest index last.
  function automatic cell_sel_t lowest_set_index(input logic [8:0] mask);
    cell_sel_t r;
    r = '0;
    for (int i = 8; i >= 0; i--) begin
      if (mask[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with synchronous clear and wrap-or-saturate at 99.
module bcd2_counter
  import tictactoe_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  bcd_digit_t tens, units;
  assign tens  = count[7:4];
  assign units = count[3:0];

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'h00;
    end else if (clr) begin
      count <= 8'h00;
    end else if (inc) begin
      if (count == BCD_MAX)
        count <= WRAP ? 8'h00 : BCD_MAX;
      else if (units == 4'd9)
        count <= {tens + 4'd1, 4'd0};
      else
        count <= {tens, units + 4'd1};
    end
  end

endmodule

// File: rtl/board_score_keeper.sv
// Board occupancy, move count, conflict flag and edge-detected BCD scoreboards
// sitting directly behind the tic-tac-toe control FSM.
module board_score_keeper #(
  parameter bit SCORE_WRAP = 1'b1,
  parameter int NCELLS     = 9
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic [NCELLS-1:0] almacenar_x,
  input  logic [NCELLS-1:0] almacenar_o,
  input  logic              resetPosiciones,
  input  logic              resetScore,
  input  logic              inc_x_score,
  input  logic              inc_o_score,
  input  logic              displayEmpate,
  output logic [NCELLS-1:0] x,
  output logic [NCELLS-1:0] o,
  output logic [3:0]        moves,
  output logic              board_full,
  output logic [7:0]        score_x,
  output logic [7:0]        score_o,
  output logic [7:0]        score_draw,
  output logic              conflict_err
);
  import tictactoe_pkg::*;

  cell_sel_t         cx, co;
  logic [NCELLS-1:0] occ;
  logic              same_cell, x_ok, o_ok, conflict_now;
  logic [4:0]        move_sum;
  logic              prev_x, prev_o, prev_d;

  assign cx  = lowest_set_index(almacenar_x);
  assign co  = lowest_set_index(almacenar_o);
  assign occ = x | o;

  assign same_cell = cx.valid && co.valid && (cx.idx == co.idx);
  assign x_ok      = cx.valid && !occ[cx.idx] && !same_cell;
  assign o_ok      = co.valid && !occ[co.idx] && !same_cell;

  // Any extra mask bit, a same-cell collision, or a hit on an occupied cell.
  assign conflict_now = (|(almacenar_x & (almacenar_x - NCELLS'(1)))) ||
                        (|(almacenar_o & (almacenar_o - NCELLS'(1)))) ||
                        same_cell ||
                        (cx.valid && occ[cx.idx]) ||
                        (co.valid && occ[co.idx]);

  assign move_sum   = {1'b0, moves} + 5'(x_ok) + 5'(o_ok);
  assign board_full = (moves == 4'd9);

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      x            <= '0;
      o            <= '0;
      moves        <= 4'd0;
      conflict_err <= 1'b0;
    end else if (resetPosiciones) begin
      x            <= '0;
      o            <= '0;
      moves        <= 4'd0;
      conflict_err <= 1'b0;
    end else begin
      if (x_ok) x[cx.idx] <= 1'b1;
      if (o_ok) o[co.idx] <= 1'b1;
      moves <= (move_sum > 5'd9) ? 4'd9 : move_sum[3:0];
      if (conflict_now) conflict_err <= 1'b1;
    end
  end

  // Previous levels keep tracking through resetScore so a held level never recounts.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      prev_x <= 1'b0;
      prev_o <= 1'b0;
      prev_d <= 1'b0;
    end else begin
      prev_x <= inc_x_score;
      prev_o <= inc_o_score;
      prev_d <= displayEmpate;
    end
  end

  bcd2_counter #(.WRAP(SCORE_WRAP)) u_score_x (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .clr(resetScore),
    .inc(inc_x_score & ~prev_x), .count(score_x)
  );

  bcd2_counter #(.WRAP(SCORE_WRAP)) u_score_o (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .clr(resetScore),
    .inc(inc_o_score & ~prev_o), .count(score_o)
  );

  bcd2_counter #(.WRAP(SCORE_WRAP)) u_score_draw (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .clr(resetScore),
    .inc(displayEmpate & ~prev_d), .count(score_draw)
  );

endmodule

// File: tb/tb_board_score_keeper.sv
// Bench for board_score_keeper: directed scenarios plus randomized traffic against a cell-array model.
module tb_board_score_keeper;

  logic       clk_100MHz = 1'b0;
  logic       reset_n = 1'b0;
  logic [8:0] almacenar_x = '0, almacenar_o = '0;
  logic       resetPosiciones = 0, resetScore = 0;
  logic       inc_x_score = 0, inc_o_score = 0, displayEmpate = 0;

  logic [8:0] x, o, x_s, o_s;
  logic [3:0] moves, moves_s;
  logic       board_full, board_full_s, conflict_err, conflict_err_s;
  logic [7:0] score_x, score_o, score_draw, score_x_s, score_o_s, score_draw_s;

  int checks = 0;
  int failures = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  board_score_keeper #(.SCORE_WRAP(1'b1)) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n),
    .almacenar_x(almacenar_x), .almacenar_o(almacenar_o),
    .resetPosiciones(resetPosiciones), .resetScore(resetScore),
    .inc_x_score(inc_x_score), .inc_o_score(inc_o_score), .displayEmpate(displayEmpate),
    .x(x), .o(o), .moves(moves), .board_full(board_full),
    .score_x(score_x), .score_o(score_o), .score_draw(score_draw),
    .conflict_err(conflict_err)
  );

  board_score_keeper #(.SCORE_WRAP(1'b0)) dut_sat (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n),
    .almacenar_x(almacenar_x), .almacenar_o(almacenar_o),
    .resetPosiciones(resetPosiciones), .resetScore(resetScore),
    .inc_x_score(inc_x_score), .inc_o_score(inc_o_score), .displayEmpate(displayEmpate),
    .x(x_s), .o(o_s), .moves(moves_s), .board_full(board_full_s),
    .score_x(score_x_s), .score_o(score_o_s), .score_draw(score_draw_s),
    .conflict_err(conflict_err_s)
  );

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic pulse_x(input int n);
    for (int i = 0; i < n; i++) begin
      inc_x_score = 1'b1; tick();
      inc_x_score = 1'b0; tick();
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if (x !== 9'h000 || o !== 9'h000 || moves !== 4'd0 || board_full !== 1'b0 ||
        score_x !== 8'h00 || score_o !== 8'h00 || score_draw !== 8'h00 || conflict_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial x=%h o=%h moves=%0d sx=%h so=%h sd=%h ce=%b expected all zero",
               x, o, moves, score_x, score_o, score_draw, conflict_err);
    end
    // Input high on the first cycle out of reset counts once.
    inc_x_score = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    inc_x_score = 1'b0;
    checks++;
    if (score_x !== 8'h01) begin
      failures++;
      $display("FAIL reset_first_cycle_inc score_x=%h expected=01", score_x);
    end
    for (int i = 0; i < 8; i++) begin
      almacenar_x = 9'(1 << i); tick();
    end
    almacenar_x = 9'h001; tick();
    almacenar_x = '0;
    checks++;
    if (x !== 9'h0FF || conflict_err !== 1'b1 || moves !== 4'd8) begin
      failures++;
      $display("FAIL reset_setup x=%h ce=%b moves=%0d expected x=0ff ce=1 moves=8", x, conflict_err, moves);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (x !== 9'h000 || o !== 9'h000 || moves !== 4'd0 || score_x !== 8'h00 || conflict_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_async x=%h o=%h moves=%0d sx=%h ce=%b expected all zero",
               x, o, moves, score_x, conflict_err);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_placement();
    almacenar_x = 9'h010; tick(); almacenar_x = '0;
    almacenar_o = 9'h001; tick(); almacenar_o = '0;
    checks++;
    if (x !== 9'h010 || o !== 9'h001 || moves !== 4'd2 || conflict_err !== 1'b0) begin
      failures++;
      $display("FAIL placement_legal x=%h o=%h moves=%0d ce=%b expected x=010 o=001 moves=2 ce=0",
               x, o, moves, conflict_err);
    end
    almacenar_x = 9'h001; tick(); almacenar_x = '0;
    checks++;
    if (x !== 9'h010 || o !== 9'h001 || moves !== 4'd2 || conflict_err !== 1'b1) begin
      failures++;
      $display("FAIL placement_occupied x=%h o=%h moves=%0d ce=%b expected x=010 o=001 moves=2 ce=1",
               x, o, moves, conflict_err);
    end
  endtask

  task automatic test_collision();
    resetPosiciones = 1'b1; tick(); resetPosiciones = 1'b0;
    almacenar_x = 9'h004; tick(); almacenar_x = '0;
    almacenar_x = 9'h100; almacenar_o = 9'h100; tick();
    almacenar_x = '0; almacenar_o = '0;
    checks++;
    if (x !== 9'h004 || o !== 9'h000 || moves !== 4'd1 || conflict_err !== 1'b1) begin
      failures++;
      $display("FAIL collision_same_cell x=%h o=%h moves=%0d ce=%b expected x=004 o=000 moves=1 ce=1",
               x, o, moves, conflict_err);
    end
    resetPosiciones = 1'b1; almacenar_x = 9'h002; tick();
    resetPosiciones = 1'b0; almacenar_x = '0;
    checks++;
    if (x !== 9'h000 || o !== 9'h000 || moves !== 4'd0 || conflict_err !== 1'b0) begin
      failures++;
      $display("FAIL collision_clear x=%h o=%h moves=%0d ce=%b expected all zero", x, o, moves, conflict_err);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) almacenar_x = 9'(1 << i);
      else            almacenar_o = 9'(1 << i);
      tick();
      almacenar_x = '0; almacenar_o = '0;
    end
    checks++;
    if (x !== 9'h155 || o !== 9'h0AA || moves !== 4'd9 || board_full !== 1'b1 || conflict_err !== 1'b0) begin
      failures++;
      $display("FAIL fill_board x=%h o=%h moves=%0d full=%b ce=%b expected x=155 o=0aa moves=9 full=1 ce=0",
               x, o, moves, board_full, conflict_err);
    end
    almacenar_o = 9'h001; tick(); almacenar_o = '0;
    checks++;
    if (x !== 9'h155 || o !== 9'h0AA || moves !== 4'd9 || conflict_err !== 1'b1) begin
      failures++;
      $display("FAIL fill_tenth x=%h o=%h moves=%0d ce=%b expected x=155 o=0aa moves=9 ce=1",
               x, o, moves, conflict_err);
    end
    almacenar_x = 9'h003; almacenar_o = 9'h0C0;
    resetPosiciones = 1'b1; tick(); resetPosiciones = 1'b0; tick();
    almacenar_x = '0; almacenar_o = '0;
    checks++;
    if (x !== 9'h001 || o !== 9'h040 || moves !== 4'd2 || conflict_err !== 1'b1) begin
      failures++;
      $display("FAIL multi_bit_mask x=%h o=%h moves=%0d ce=%b expected x=001 o=040 moves=2 ce=1",
               x, o, moves, conflict_err);
    end
  endtask

  task automatic test_score_edge();
    resetScore = 1'b1; tick(); resetScore = 1'b0;
    inc_x_score = 1'b1;
    repeat (50) tick();
    inc_x_score = 1'b0; tick();
    checks++;
    if (score_x !== 8'h01) begin
      failures++;
      $display("FAIL score_held_level score_x=%h expected=01", score_x);
    end
    pulse_x(3);
    checks++;
    if (score_x !== 8'h04) begin
      failures++;
      $display("FAIL score_pulses score_x=%h expected=04", score_x);
    end
    displayEmpate = 1'b1; tick(); tick(); displayEmpate = 1'b0; tick();
    checks++;
    if (score_draw !== 8'h01 || score_o !== 8'h00 || score_x !== 8'h04) begin
      failures++;
      $display("FAIL score_draw sd=%h so=%h sx=%h expected sd=01 so=00 sx=04", score_draw, score_o, score_x);
    end
  endtask

  task automatic test_bcd_carry();
    resetScore = 1'b1; tick(); resetScore = 1'b0;
    pulse_x(9);
    checks++;
    if (score_x !== 8'h09) begin
      failures++;
      $display("FAIL bcd_nine score_x=%h expected=09", score_x);
    end
    pulse_x(1);
    checks++;
    if (score_x !== 8'h10) begin
      failures++;
      $display("FAIL bcd_carry score_x=%h expected=10", score_x);
    end
    pulse_x(89);
    checks++;
    if (score_x !== 8'h99 || score_x_s !== 8'h99) begin
      failures++;
      $display("FAIL bcd_reach_99 wrap=%h sat=%h expected both 99", score_x, score_x_s);
    end
    pulse_x(1);
    checks++;
    if (score_x !== 8'h00) begin
      failures++;
      $display("FAIL bcd_wrap score_x=%h expected=00", score_x);
    end
    checks++;
    if (score_x_s !== 8'h99) begin
      failures++;
      $display("FAIL bcd_saturate score_x=%h expected=99", score_x_s);
    end
  endtask

  task automatic test_reset_score_override();
    resetScore = 1'b1; tick(); resetScore = 1'b0;
    inc_o_score = 1'b1; tick(); inc_o_score = 1'b0; tick();
    checks++;
    if (score_o !== 8'h01) begin
      failures++;
      $display("FAIL override_setup score_o=%h expected=01", score_o);
    end
    resetScore = 1'b1; inc_o_score = 1'b1; tick();
    resetScore = 1'b0;
    repeat (5) tick();
    checks++;
    if (score_o !== 8'h00) begin
      failures++;
      $display("FAIL override_clear score_o=%h expected=00", score_o);
    end
    inc_o_score = 1'b0; tick(); inc_o_score = 1'b1; tick(); inc_o_score = 1'b0;
    checks++;
    if (score_o !== 8'h01) begin
      failures++;
      $display("FAIL override_recount score_o=%h expected=01", score_o);
    end
  endtask

  task automatic test_random();
    int owner[9];
    int mcount, nx, no, nd, nxs;
    bit cerr, px, po, pd;
    int lx, lo;
    logic [8:0] ex, eo;

    almacenar_x = '0; almacenar_o = '0;
    inc_x_score = 0; inc_o_score = 0; displayEmpate = 0;
    resetPosiciones = 1'b1; resetScore = 1'b1; tick(); tick();
    resetPosiciones = 1'b0; resetScore = 1'b0;
    foreach (owner[i]) owner[i] = 0;
    mcount = 0; cerr = 0; nx = 0; no = 0; nd = 0; nxs = 0;
    px = 0; po = 0; pd = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        logic [8:0] m;
        int mode;
        mode = $urandom_range(0, 9);
        if (mode < 4)      m = '0;
        else if (mode < 8) m = 9'(1 << $urandom_range(0, 8));
        else if (mode < 9) m = 9'($urandom);
        else               m = 9'(1 << $urandom_range(0, 2));
        if (k == 0) almacenar_x = m; else almacenar_o = m;
      end
      resetPosiciones = ($urandom_range(0, 24) == 0);
      resetScore      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) inc_x_score   = ~inc_x_score;
      if ($urandom_range(0, 3) == 0) inc_o_score   = ~inc_o_score;
      if ($urandom_range(0, 5) == 0) displayEmpate = ~displayEmpate;

      if (resetPosiciones) begin
        foreach (owner[i]) owner[i] = 0;
        mcount = 0; cerr = 0;
      end else begin
        lx = -1; lo = -1;
        for (int i = 8; i >= 0; i--) begin
          if (almacenar_x[i]) lx = i;
          if (almacenar_o[i]) lo = i;
        end
        if ($countones(almacenar_x) > 1 || $countones(almacenar_o) > 1) cerr = 1;
        if (lx >= 0 && lx == lo) begin
          cerr = 1;
        end else begin
          if (lx >= 0 && owner[lx] != 0) cerr = 1;
          if (lo >= 0 && owner[lo] != 0) cerr = 1;
          if (lx >= 0 && owner[lx] == 0) begin owner[lx] = 1; mcount++; end
          if (lo >= 0 && owner[lo] == 0) begin owner[lo] = 2; mcount++; end
          if (mcount > 9) mcount = 9;
        end
      end

      if (resetScore) begin
        nx = 0; no = 0; nd = 0; nxs = 0;
      end else begin
        if (inc_x_score && !px) begin nx = (nx + 1) % 100; nxs = (nxs < 99) ? nxs + 1 : 99; end
        if (inc_o_score && !po) no = (no + 1) % 100;
        if (displayEmpate && !pd) nd = (nd + 1) % 100;
      end
      px = inc_x_score; po = inc_o_score; pd = displayEmpate;

      ex = '0; eo = '0;
      for (int i = 0; i < 9; i++) begin
        ex[i] = (owner[i] == 1);
        eo[i] = (owner[i] == 2);
      end

      tick();

      checks++;
      if (x !== ex || o !== eo) begin
        failures++;
        $display("FAIL rand_board cyc=%0d x=%h o=%h expected x=%h o=%h", cyc, x, o, ex, eo);
      end
      checks++;
      if (moves !== 4'(mcount) || board_full !== (mcount == 9)) begin
        failures++;
        $display("FAIL rand_moves cyc=%0d moves=%0d full=%b expected moves=%0d", cyc, moves, board_full, mcount);
      end
      checks++;
      if (conflict_err !== cerr) begin
        failures++;
        $display("FAIL rand_conflict cyc=%0d ce=%b expected=%b", cyc, conflict_err, cerr);
      end
      checks++;
      if (score_x !== to_bcd(nx) || score_o !== to_bcd(no) || score_draw !== to_bcd(nd) ||
          score_x_s !== to_bcd(nxs)) begin
        failures++;
        $display("FAIL rand_scores cyc=%0d sx=%h so=%h sd=%h sxs=%h expected sx=%h so=%h sd=%h sxs=%h",
                 cyc, score_x, score_o, score_draw, score_x_s, to_bcd(nx), to_bcd(no), to_bcd(nd), to_bcd(nxs));
      end
    end
    almacenar_x = '0; almacenar_o = '0;
    resetPosiciones = 0; resetScore = 0;
  endtask

  initial begin
    test_reset();
    test_placement();
    test_collision();
    test_fill();
    test_score_edge();
    test_bcd_carry();
    test_reset_score_override();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
